// File: rtl/alu_pkg.sv
// Shared definitions for the ALU serial protocol: frame constants, error flag
// layout and the CRC3 used on the control frame of a data response.
package alu_pkg;

  localparam int   FRAME_BITS  = 11;
  localparam int   DATA_FRAMES = 4;
  localparam logic TYPE_DATA   = 1'b0;
  localparam logic TYPE_CMD    = 1'b1;

  typedef struct packed {
    logic data;
    logic crc;
    logic op;
  } err_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ser_state_t;

  // x^3+x+1, initial value 0, message consumed MSB first.
  function automatic logic [2:0] crc3_calc(input logic [36:0] vec);
    logic [2:0] crc;
    logic       fb;
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = vec[i] ^ crc[2];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_frame_shifter.sv
// Sends one 11-bit frame MSB first on a registered serial line; the line
// rests high whenever no frame is being shifted.
module alu_frame_shifter
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  bit_penult
);

  logic [FRAME_BITS-2:0] sr;
  logic [3:0]            bit_cnt;

  // A load wins over shifting so the top can chain frames with no idle bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '1;
      bit_cnt <= 4'd0;
      busy    <= 1'b0;
      sout    <= 1'b1;
    end else if (load) begin
      sout    <= frame[FRAME_BITS-1];
      sr      <= frame[FRAME_BITS-2:0];
      bit_cnt <= 4'd0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (frame_done) begin
        busy    <= 1'b0;
        sout    <= 1'b1;
        bit_cnt <= 4'd0;
      end else begin
        sout    <= sr[FRAME_BITS-2];
        sr      <= {sr[FRAME_BITS-3:0], 1'b1};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  assign frame_done = busy && (bit_cnt == 4'(FRAME_BITS - 1));
  assign bit_penult = busy && (bit_cnt == 4'(FRAME_BITS - 2));

endmodule

// File: rtl/alu_sout_serializer.sv
// Response transmitter: captures one result or error report per handshake and
// sequences its frames through alu_frame_shifter onto sout.
module alu_sout_serializer
  import alu_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_err,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_flags,
  input  logic [2:0]  req_err,
  output logic        sout,
  output logic        busy
);

  // Handshake: a request transfers on any rising edge where req_valid and
  // req_ready are both 1; req_ready never depends on req_valid, and inputs
  // seen while req_ready is 0 are ignored.

  ser_state_t state, state_nxt;
  logic        ready_en;
  logic        is_err_q;
  logic [31:0] data_q;
  logic [3:0]  flags_q;
  logic [2:0]  crc_q;
  logic [5:0]  err6_q;
  logic        par_q;
  logic [2:0]  frame_cnt;
  logic [3:0]  gap_cnt;
  logic        accept, load, last_frame, gap_last;
  logic        sh_busy, frame_done, bit_penult;
  logic [2:0]  load_idx;
  logic [FRAME_BITS-1:0] frame;
  err_flags_t  err_in;

  assign err_in     = err_flags_t'(req_err);
  assign accept     = req_valid && req_ready;
  assign gap_last   = (gap_cnt == 4'(IDLE_GAP - 1));
  assign last_frame = is_err_q ? (frame_cnt == 3'd0) : (frame_cnt == 3'(DATA_FRAMES));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // SEND ends as the final bit is launched, so GAP's last cycle lines up with
  // the last idle-high bit and a new request can be taken there.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_SEND;
      ST_SEND: if (bit_penult && last_frame) state_nxt = ST_GAP;
      ST_GAP: begin
        if (accept)        state_nxt = ST_SEND;
        else if (gap_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = ready_en && ((state == ST_IDLE) || (state == ST_GAP && gap_last));
    load      = 1'b0;
    load_idx  = 3'd0;
    if (state == ST_SEND) begin
      if (!sh_busy) begin
        load = 1'b1;
      end else if (frame_done && !last_frame) begin
        load     = 1'b1;
        load_idx = frame_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_err_q <= 1'b0;
      data_q   <= 32'd0;
      flags_q  <= 4'd0;
      crc_q    <= 3'd0;
      err6_q   <= 6'd0;
      par_q    <= 1'b0;
    end else if (accept) begin
      is_err_q <= req_is_err;
      data_q   <= req_data;
      flags_q  <= req_flags;
      crc_q    <= crc3_calc({req_data, 1'b0, req_flags});
      err6_q   <= {err_in, err_in};
      par_q    <= ^{1'b1, err_in, err_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      frame_cnt <= 3'd0;
    else if (accept) frame_cnt <= 3'd0;
    else if (load)   frame_cnt <= load_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                   gap_cnt <= 4'd0;
    else if (state == ST_GAP && state_nxt == ST_GAP) gap_cnt <= gap_cnt + 4'd1;
    else                                          gap_cnt <= 4'd0;
  end

  always_comb begin
    frame = {1'b0, TYPE_CMD, 1'b0, flags_q, crc_q, 1'b1};
    if (is_err_q) begin
      frame = {1'b0, TYPE_CMD, 1'b1, err6_q, par_q, 1'b1};
    end else begin
      unique case (load_idx)
        3'd0:    frame = {1'b0, TYPE_DATA, data_q[31:24], 1'b1};
        3'd1:    frame = {1'b0, TYPE_DATA, data_q[23:16], 1'b1};
        3'd2:    frame = {1'b0, TYPE_DATA, data_q[15:8],  1'b1};
        3'd3:    frame = {1'b0, TYPE_DATA, data_q[7:0],   1'b1};
        default: frame = {1'b0, TYPE_CMD, 1'b0, flags_q, crc_q, 1'b1};
      endcase
    end
  end

  alu_frame_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .frame      (frame),
    .sout       (sout),
    .busy       (sh_busy),
    .frame_done (frame_done),
    .bit_penult (bit_penult)
  );

  assign busy = sh_busy;

endmodule

// File: tb/tb_alu_sout_serializer.sv
// Directed bench for alu_sout_serializer: frame contents, latency, spacing
// between responses, input isolation and reset behaviour.
module tb_alu_sout_serializer;

  localparam int G = 3;

  localparam logic [54:0] RESP_ZERO = {11'b00000000001, 11'b00000000001, 11'b00000000001,
                                       11'b00000000001, 11'b01000101101};
  localparam logic [54:0] RESP_DEAD = {11'b00110111101, 11'b00101011011, 11'b00101111101,
                                       11'b00111011111, 11'b01010011011};
  localparam logic [54:0] ERR_001 = {44'd0, 11'b01100100111};
  localparam logic [54:0] ERR_110 = {44'd0, 11'b01111011011};
  localparam logic [54:0] ERR_010 = {44'd0, 11'b01101001011};
  localparam logic [54:0] ERR_111 = {44'd0, 11'b01111111111};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_is_err = 1'b0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  req_flags = 4'd0;
  logic [2:0]  req_err = 3'd0;
  logic        req_ready, sout, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  alu_sout_serializer #(.IDLE_GAP(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_is_err (req_is_err),
    .req_data   (req_data),
    .req_flags  (req_flags),
    .req_err    (req_err),
    .sout       (sout),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // driver: present a request and return once it has been accepted
  task automatic do_handshake(input logic is_err, input logic [31:0] d, input logic [3:0] f,
                              input logic [2:0] e, output int hs, output bit tmo);
    int w = 0;
    req_valid = 1'b1; req_is_err = is_err; req_data = d; req_flags = f; req_err = e;
    while (req_ready !== 1'b1 && w < 300) begin
      @(posedge clk); #1; w++;
    end
    tmo = (w >= 300);
    if (!tmo) begin
      @(posedge clk); #1;
    end
    hs = cyc;
  endtask

  // receiver: count idle-high cycles, then collect n bits from the start bit
  task automatic rx_resp(input int n, output logic [54:0] bits, output int idle,
                         output int start_cyc, output bit tmo, output bit busy_ok);
    bits = '0; idle = 0; busy_ok = 1'b1;
    @(negedge clk);
    while (sout === 1'b1 && idle < 300) begin
      if (busy !== 1'b0) busy_ok = 1'b0;
      idle++;
      @(negedge clk);
    end
    tmo = (idle >= 300);
    start_cyc = cyc;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      bits = {bits[53:0], sout};
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (sout !== 1'b1) begin n_err++; $display("FAIL reset_sout: got %b expected 1", sout); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b expected 0", req_ready); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b expected 1", req_ready); end
  endtask

  task automatic test_zero();
    int hs, idle, sc; bit tmo, tmo2, bok; logic [54:0] bits;
    do_handshake(1'b0, 32'h0, 4'b0010, 3'b000, hs, tmo);
    req_valid = 1'b0;
    n_cmp++; if (tmo) begin n_err++; $display("FAIL zero_accept: got timeout expected handshake"); end
    rx_resp(55, bits, idle, sc, tmo2, bok);
    n_cmp++; if (tmo2) begin n_err++; $display("FAIL zero_start: got timeout expected start bit"); end
    n_cmp++; if (sc - hs !== 1) begin n_err++; $display("FAIL zero_latency: got %0d expected 1", sc - hs); end
    n_cmp++; if (bits !== RESP_ZERO) begin n_err++; $display("FAIL zero_bits: got %h expected %h", bits, RESP_ZERO); end
    n_cmp++; if (!bok) begin n_err++; $display("FAIL zero_busy: got busy out of step expected busy only on bits"); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || sout !== 1'b1) begin n_err++; $display("FAIL zero_end: got busy=%b sout=%b expected 0/1", busy, sout); end
  endtask

  task automatic test_op_err();
    int hs1, hs2, idle, sc; bit tmo1, tmo, tmo2, bok; logic [54:0] bits;
    do_handshake(1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, hs1, tmo1);
    n_cmp++; if (tmo1) begin n_err++; $display("FAIL err_accept: got timeout expected handshake"); end
    fork
      rx_resp(11, bits, idle, sc, tmo2, bok);
      do_handshake(1'b1, 32'h0, 4'h0, 3'b110, hs2, tmo);
    join
    req_valid = 1'b0;
    n_cmp++; if (bits !== ERR_001) begin n_err++; $display("FAIL err001_bits: got %h expected %h", bits, ERR_001); end
    n_cmp++; if (sc - hs1 !== 1) begin n_err++; $display("FAIL err_latency: got %0d expected 1", sc - hs1); end
    n_cmp++; if (!bok) begin n_err++; $display("FAIL err_busy: got busy out of step expected busy only on bits"); end
    n_cmp++; if (tmo || hs2 - hs1 !== 11 + G) begin n_err++; $display("FAIL err_ready_gap: got %0d expected %0d", hs2 - hs1, 11 + G); end
    rx_resp(11, bits, idle, sc, tmo2, bok);
    n_cmp++; if (bits !== ERR_110) begin n_err++; $display("FAIL err110_bits: got %h expected %h", bits, ERR_110); end
  endtask

  task automatic test_capture_hold();
    int hs, idle, sc; bit tmo, tmo2, bok; logic [54:0] bits;
    do_handshake(1'b0, 32'hDEAD_BEEF, 4'b1001, 3'b000, hs, tmo);
    req_valid = 1'b0; req_data = 32'h1234_5678; req_flags = 4'b0110; req_is_err = 1'b1; req_err = 3'b101;
    rx_resp(55, bits, idle, sc, tmo2, bok);
    n_cmp++; if (tmo || tmo2) begin n_err++; $display("FAIL dead_handshake: got timeout expected response"); end
    n_cmp++; if (bits !== RESP_DEAD) begin n_err++; $display("FAIL dead_bits: got %h expected %h", bits, RESP_DEAD); end
    n_cmp++; if (bits[3:1] !== 3'b101) begin n_err++; $display("FAIL dead_crc: got %b expected 101", bits[3:1]); end
  endtask

  task automatic test_guard();
    int hs, idle, sc, extra; bit tmo, tmo2, bok; logic [54:0] bits;
    do_handshake(1'b1, 32'h0, 4'h0, 3'b111, hs, tmo);
    req_err = 3'b010; req_is_err = 1'b1;
    fork
      rx_resp(11, bits, idle, sc, tmo2, bok);
      begin
        repeat (5) @(negedge clk);
        req_valid = 1'b0;
      end
    join
    n_cmp++; if (bits !== ERR_111) begin n_err++; $display("FAIL guard_bits: got %h expected %h", bits, ERR_111); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || sout !== 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL guard_no_latch: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic        t_err  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] t_data [7] = '{32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [3:0]  t_flag [7] = '{4'b0010, 4'h0, 4'b1001, 4'b0010, 4'h0, 4'h0, 4'h0};
    logic [2:0]  t_errb [7] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b110, 3'b010, 3'b111};
    logic [54:0] exp_q[$];
    int          len_q[$];
    int          extra;
    exp_q = '{RESP_ZERO, ERR_001, RESP_DEAD, RESP_ZERO, ERR_110, ERR_010, ERR_111};
    len_q = '{55, 11, 55, 55, 11, 11, 11};
    fork
      begin
        int hs; bit tmo;
        for (int i = 0; i < 7; i++) begin
          do_handshake(t_err[i], t_data[i], t_flag[i], t_errb[i], hs, tmo);
          if (tmo) break;
        end
        req_valid = 1'b0;
      end
      begin
        int idle, sc; bit tmo2, bok; logic [54:0] bits; logic [54:0] exp_v;
        for (int i = 0; i < 7; i++) begin
          exp_v = exp_q.pop_front();
          rx_resp(len_q[i], bits, idle, sc, tmo2, bok);
          n_cmp++; if (bits !== exp_v) begin n_err++; $display("FAIL b2b_bits[%0d]: got %h expected %h", i, bits, exp_v); end
          if (i > 0) begin
            n_cmp++; if (idle !== G) begin n_err++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", i, idle, G); end
          end
          n_cmp++; if (!bok) begin n_err++; $display("FAIL b2b_busy[%0d]: got busy out of step expected busy only on bits", i); end
          if (tmo2) break;
        end
      end
    join
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL b2b_no_dup: got %0d busy cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int hs, idle, sc, bad; bit tmo, tmo2, bok; logic [54:0] bits;
    do_handshake(1'b0, 32'hA5A5_A5A5, 4'b0101, 3'b000, hs, tmo);
    req_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (sout !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL mid_reset: got sout=%b busy=%b expected 1/0", sout, busy); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (sout !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL mid_no_resume: got %0d active cycles expected 0", bad); end
    do_handshake(1'b0, 32'h0, 4'b0010, 3'b000, hs, tmo);
    req_valid = 1'b0;
    rx_resp(55, bits, idle, sc, tmo2, bok);
    n_cmp++; if (bits !== RESP_ZERO || tmo) begin n_err++; $display("FAIL mid_clean_resp: got %h expected %h", bits, RESP_ZERO); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_op_err();
    test_capture_hold();
    test_guard();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sout_serializer.md
# alu_sout_serializer

Response transmitter for the ALU serial protocol. It accepts one result (a 32-bit value plus flags) or one error report per handshake, then serialises it onto `sout` as 11-bit frames, one bit per clock. It sits between the ALU core and the `sout` pin of `mtm_Alu`, and is the sending end of the frames the host receiver decodes.

## Interface
- `IDLE_GAP`, default 1: minimum number of idle-high cycles between two responses. Legal range is 1..15.
- `clk`  in  1: sole clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous reset, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request.
- `req_is_err`  in  1: 1 = error response, 0 = data response.
- `req_data`  in  32: ALU result C.
- `req_flags`  in  4: {carry, overflow, zero, negative}.
- `req_err`  in  3: {err_data, err_crc, err_op}.
- `sout`  out  1: serial line, idle high.
- `busy`  out  1: a response is being transmitted.

## Operation
- **Frame format.** Each frame is 11 bits, sent MSB first: start `0`, type bit, 8 payload bits, stop `1`.
- **Data response.** Five contiguous frames, 55 bits in total:
  - Four data frames `{0,0,byte,1}`, carrying C[31:24], C[23:16], C[15:8], C[7:0] in that order.
  - One control frame `{0,1,0,flags[3:0],crc3[2:0],1}`.
- **CRC3.**
  - Polynomial x^3+x+1, initial value 0.
  - Computed over the 37-bit vector `{C[31:0], 1'b0, flags[3:0]}`, MSB first.
- **Error response.** One frame `{0,1,1,err6[5:0],par,1}`.
  - `err6 = {req_err, req_err}`.
  - `par = ^{1'b1, err6}`, which makes the 8 payload bits even parity.
- **Request capture.**
  - A request is captured on the edge where `req_valid && req_ready`.
  - All request fields are registered at capture. Later changes to the inputs have no effect on the response in flight.
  - CRC3 or parity is computed at capture.
- **FSM states.**
  - IDLE: `req_ready=1`. On handshake, go to SEND.
  - SEND: shift out frames. On the last bit of the last frame, go to GAP.
  - GAP: hold `sout=1` for `IDLE_GAP` cycles, then go to IDLE.
- **Counters.** A bit counter (0..10) and a frame counter (0..4; the last frame is frame 0 for an error response, frame 4 for a data response).

## Timing
- **Reset values.** `sout=1`, `req_ready=0` in the reset cycle, `busy=0`. All counters are 0 and the state is IDLE.
- **Out of reset.** `req_ready` rises on the first edge after `rst_n` goes high.
- **Latency.**
  - If the handshake occurs on edge N, the start bit appears on `sout` after edge N+1 (registered output).
  - Each subsequent bit advances one edge later.
  - Frames within a response are back-to-back with no idle bits.
- **Response length.**
  - A data response occupies 55 cycles; an error response occupies 11 cycles.
  - `busy=1` exactly while bits are being driven.
- **Ready.**
  - `req_ready=0` from the edge after the handshake until GAP completes.
  - The earliest next start bit is 55+`IDLE_GAP` cycles (data) or 11+`IDLE_GAP` cycles (error) after the previous start bit.
  - A request held valid during busy is accepted on the first IDLE cycle; it is neither lost nor duplicated.
- **Reset mid-frame.** The response is aborted. `sout` returns to 1 on that edge and no partial frame resumes.
- **Undefined-data guard.** `req_valid` sampled while not ready is ignored; the serializer does not latch it early.

## Structure
- **Package `alu_pkg`.**
  - Constants: `FRAME_BITS=11`, `DATA_FRAMES=4`, `TYPE_DATA=1'b0`, `TYPE_CMD=1'b1`.
  - Typedef `err_flags_t` for the `{data,crc,op}` bits.
  - Function `crc3_calc(input [36:0])`.
  - The host bench reuses this package.
- **Sub-module `alu_frame_shifter`.**
  - Loads an 11-bit frame, shifts it MSB first, and pulses `frame_done` on the last bit.
  - The top FSM only sequences frames.

## Test plan
- **Zero result.** C=0, flags=4'b0010, `req_is_err=0` -> four frames `0_0_00000000_1`, then control `0_1_0_0010_110_1`; 55 bits total; start bit one cycle after the handshake.
- **Op error.** `req_is_err=1`, `req_err=3'b001` -> single frame `0_1_1_001001_1_1`; `req_ready` low for 11+`IDLE_GAP` cycles.
- **Byte order and CRC.** C=32'hDEADBEEF, flags=4'b1001 -> data bytes DE, AD, BE, EF in order; control CRC equals `crc3_calc({32'hDEADBEEF,1'b0,4'b1001})`.
- **Back-to-back requests.** `req_valid` held high with new data every accept -> exactly `IDLE_GAP` high cycles between responses; no request dropped or duplicated across 100 random requests.
- **Reset mid-transmit.** `rst_n` low during bit 20 of a data response -> `sout=1` on the next edge, `busy=0`; the next request transmits cleanly.
- **Input change after capture.** `req_data` changes while busy -> the transmitted bytes match the captured value.
